// File: rtl/exec_multicycle_if.sv
// Instruction-in / result-out bundle for exec_multicycle.
// The slave modport is the execute unit's view; master is the issuing side.
interface exec_multicycle_if #(
  parameter int W_OPR = 32,
  parameter int W_IMM = 16,
  parameter int W_RD  = 5
);
  logic             v_i;
  logic             stall_i;
  logic             stall_o;
  logic             busy_o;
  logic [6:0]       opecode_i;
  logic [W_OPR-1:0] opr0_i;
  logic [W_OPR-1:0] opr1_i;
  logic [W_IMM-1:0] imm_i;
  logic             immf_i;
  logic             immsign_i;
  logic             wb_i;
  logic [W_RD-1:0]  wb_r_i;
  logic             v_o;
  logic [W_OPR-1:0] result_o;
  logic             wb_o;
  logic [W_RD-1:0]  wb_r_o;
  logic [3:0]       flags_o;

  modport slave (
    input  v_i, stall_i, opecode_i, opr0_i, opr1_i, imm_i, immf_i, immsign_i, wb_i, wb_r_i,
    output stall_o, busy_o, v_o, result_o, wb_o, wb_r_o, flags_o
  );

  modport master (
    output v_i, stall_i, opecode_i, opr0_i, opr1_i, imm_i, immf_i, immsign_i, wb_i, wb_r_i,
    input  stall_o, busy_o, v_o, result_o, wb_o, wb_r_o, flags_o
  );
endinterface

// File: rtl/exec_multicycle.sv
// Execute stage: single-cycle ADD/SUB/MUL/CMP/NOP plus an optional multicycle
// restoring divider enabled by the macro EXEC_MULTICYCLE_DIV_EN.
module exec_multicycle #(
  parameter int W_OPR = 32,
  parameter int W_IMM = 16,
  parameter int W_RD  = 5
) (
  input logic              clk,
  input logic              reset,
  exec_multicycle_if.slave bus
);

  localparam logic [6:0] OP_ADD  = 7'd0;
  localparam logic [6:0] OP_SUB  = 7'd1;
  localparam logic [6:0] OP_MUL  = 7'd2;
  localparam logic [6:0] OP_DIV  = 7'd3;
  localparam logic [6:0] OP_CMP  = 7'd4;
  localparam logic [6:0] OP_STOP = 7'h1F;

  logic [W_OPR-1:0] imm_ext_s;
  logic [W_OPR-1:0] opr_b_s;
  logic [W_OPR:0]   cmp_diff_s;
  logic [3:0]       cmp_flags_s;
  logic [W_OPR-1:0] alu_res_s;
  logic             alu_wb_s;
  logic             is_cmp_s;
  logic             div_start_s;
  logic             div_go_s;
  logic             accept_s;
  logic             stall_o_s;
  logic             busy_s;
  logic             done_s;
  logic             div_done_s;
  logic [W_OPR-1:0] quotient_s;
  logic             div_wb_s;
  logic [W_RD-1:0]  div_wb_r_s;

  logic             v_q, v_d;
  logic [W_OPR-1:0] result_q, result_d;
  logic             wb_q, wb_d;
  logic [W_RD-1:0]  wb_r_q, wb_r_d;
  logic [3:0]       flags_q, flags_d;

  // Operand B: register operand or sign/zero-extended immediate.
  always_comb begin
    imm_ext_s = '0;
    opr_b_s   = '0;
    if (bus.immsign_i) begin
      imm_ext_s = {{(W_OPR-W_IMM){bus.imm_i[W_IMM-1]}}, bus.imm_i};
    end else begin
      imm_ext_s = {{(W_OPR-W_IMM){1'b0}}, bus.imm_i};
    end
    if (bus.immf_i) begin
      opr_b_s = imm_ext_s;
    end else begin
      opr_b_s = bus.opr1_i;
    end
  end

  // Compare flags {C,Z,S,V}; the extra top bit of the difference is the borrow.
  always_comb begin
    cmp_diff_s  = {1'b0, bus.opr0_i} - {1'b0, opr_b_s};
    cmp_flags_s = {cmp_diff_s[W_OPR],
                   (cmp_diff_s[W_OPR-1:0] == {W_OPR{1'b0}}),
                   cmp_diff_s[W_OPR-1],
                   (bus.opr0_i[W_OPR-1] ^ opr_b_s[W_OPR-1]) &
                   (cmp_diff_s[W_OPR-1] ^ bus.opr0_i[W_OPR-1])};
  end

  // Single-cycle result and write-back qualification per opcode.
  always_comb begin
    alu_res_s   = '0;
    alu_wb_s    = bus.wb_i;
    is_cmp_s    = 1'b0;
    div_start_s = 1'b0;
    case (bus.opecode_i)
      OP_ADD: alu_res_s = bus.opr0_i + opr_b_s;
      OP_SUB: alu_res_s = bus.opr0_i - opr_b_s;
      OP_MUL: alu_res_s = bus.opr0_i * opr_b_s;
      OP_DIV: begin
`ifdef EXEC_MULTICYCLE_DIV_EN
        if (opr_b_s == {W_OPR{1'b0}}) begin
          alu_res_s = {W_OPR{1'b1}};
        end else begin
          div_start_s = 1'b1;
        end
`else
        alu_res_s = '0;
`endif
      end
      OP_CMP: begin
        is_cmp_s = 1'b1;
        alu_wb_s = 1'b0;
      end
      default: alu_res_s = '0;
    endcase
  end

  // A finishing divide owns the output register, so nothing is accepted in DONE.
  assign stall_o_s = bus.stall_i | busy_s;
  assign accept_s  = bus.v_i & ~stall_o_s & ~done_s;
  assign div_go_s  = accept_s & div_start_s;

`ifdef EXEC_MULTICYCLE_DIV_EN
  localparam int W_CNT = $clog2(W_OPR + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [W_OPR-1:0] rem_q, rem_d;
  logic [W_OPR-1:0] quo_q, quo_d;
  logic [W_OPR-1:0] dvs_q, dvs_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic             dwb_q, dwb_d;
  logic [W_RD-1:0]  dwb_r_q, dwb_r_d;
  logic [W_OPR:0]   rem_sh_s;
  logic [W_OPR:0]   trial_s;

  // Divider FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Divider FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (div_go_s) state_d = S_DIV;
        else          state_d = S_IDLE;
      end
      S_DIV: begin
        if (cnt_q == W_CNT'(1)) state_d = S_DONE;
        else                    state_d = S_DIV;
      end
      S_DONE: begin
        if (bus.stall_i) state_d = S_DONE;
        else             state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Divider FSM outputs; DONE stays busy only while held by a downstream stall.
  always_comb begin
    busy_s     = 1'b0;
    done_s     = 1'b0;
    div_done_s = 1'b0;
    case (state_q)
      S_DIV:  busy_s = 1'b1;
      S_DONE: begin
        busy_s     = bus.stall_i;
        done_s     = 1'b1;
        div_done_s = ~bus.stall_i;
      end
      default: busy_s = 1'b0;
    endcase
  end

  // Restoring step: shift in the next dividend bit, keep the difference if non-negative.
  always_comb begin
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    dwb_d    = dwb_q;
    dwb_r_d  = dwb_r_q;
    rem_sh_s = {rem_q, quo_q[W_OPR-1]};
    trial_s  = rem_sh_s - {1'b0, dvs_q};
    if (div_go_s) begin
      rem_d   = '0;
      quo_d   = bus.opr0_i;
      dvs_d   = opr_b_s;
      cnt_d   = W_CNT'(W_OPR);
      dwb_d   = bus.wb_i;
      dwb_r_d = bus.wb_r_i;
    end else if (state_q == S_DIV) begin
      cnt_d = cnt_q - W_CNT'(1);
      if (!trial_s[W_OPR]) begin
        rem_d = trial_s[W_OPR-1:0];
        quo_d = {quo_q[W_OPR-2:0], 1'b1};
      end else begin
        rem_d = rem_sh_s[W_OPR-1:0];
        quo_d = {quo_q[W_OPR-2:0], 1'b0};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Divider datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dwb_q   <= 1'b0;
      dwb_r_q <= '0;
    end else begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dwb_q   <= dwb_d;
      dwb_r_q <= dwb_r_d;
    end
  end

  assign quotient_s = quo_q;
  assign div_wb_s   = dwb_q;
  assign div_wb_r_s = dwb_r_q;
`else
  assign busy_s     = 1'b0;
  assign done_s     = 1'b0;
  assign div_done_s = 1'b0;
  assign quotient_s = '0;
  assign div_wb_s   = 1'b0;
  assign div_wb_r_s = '0;
`endif

  // Output register update: stall holds everything, a finished divide wins next.
  always_comb begin
    v_d      = v_q;
    result_d = result_q;
    wb_d     = wb_q;
    wb_r_d   = wb_r_q;
    flags_d  = flags_q;
    if (bus.stall_i) begin
      v_d = v_q;
    end else if (div_done_s) begin
      v_d      = 1'b1;
      result_d = quotient_s;
      wb_d     = div_wb_s;
      wb_r_d   = div_wb_r_s;
    end else if (accept_s && !div_start_s) begin
      v_d      = 1'b1;
      result_d = alu_res_s;
      wb_d     = alu_wb_s;
      wb_r_d   = bus.wb_r_i;
      if (is_cmp_s) begin
        flags_d = cmp_flags_s;
      end else begin
        flags_d = flags_q;
      end
    end else begin
      v_d  = 1'b0;
      wb_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q      <= 1'b0;
      result_q <= '0;
      wb_q     <= 1'b0;
      wb_r_q   <= '0;
      flags_q  <= 4'b0000;
    end else begin
      v_q      <= v_d;
      result_q <= result_d;
      wb_q     <= wb_d;
      wb_r_q   <= wb_r_d;
      flags_q  <= flags_d;
    end
  end

`ifndef SYNTHESIS
  // Simulation-only stop opcode; behaves as a NOP in hardware.
  always_ff @(posedge clk) begin
    if (reset && accept_s && (bus.opecode_i == OP_STOP)) begin
      $finish;
    end
  end
`endif

  assign bus.stall_o  = stall_o_s;
  assign bus.busy_o   = busy_s;
  assign bus.v_o      = v_q;
  assign bus.result_o = result_q;
  assign bus.wb_o     = wb_q & v_q;
  assign bus.wb_r_o   = wb_r_q;
  assign bus.flags_o  = flags_q;

endmodule

// File: tb/tb_exec_multicycle.sv
// Directed self-checking bench for exec_multicycle (W_OPR=32, W_IMM=16, W_RD=5).
// Divider scenarios follow EXEC_MULTICYCLE_DIV_EN; otherwise DIV is checked as a NOP.
module tb_exec_multicycle;

  localparam logic [6:0] OP_ADD = 7'd0;
  localparam logic [6:0] OP_SUB = 7'd1;
  localparam logic [6:0] OP_MUL = 7'd2;
  localparam logic [6:0] OP_DIV = 7'd3;
  localparam logic [6:0] OP_CMP = 7'd4;
  localparam logic [6:0] OP_NOP = 7'd5;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  exec_multicycle_if #(.W_OPR(32), .W_IMM(16), .W_RD(5)) bus ();

  exec_multicycle #(.W_OPR(32), .W_IMM(16), .W_RD(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] imm, input logic immf, input logic immsign,
                       input logic wb, input logic [4:0] rd);
    bus.opecode_i = op;
    bus.opr0_i    = a;
    bus.opr1_i    = b;
    bus.imm_i     = imm;
    bus.immf_i    = immf;
    bus.immsign_i = immsign;
    bus.wb_i      = wb;
    bus.wb_r_i    = rd;
    bus.v_i       = 1'b1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] imm, input logic immf, input logic immsign,
                       input logic wb, input logic [4:0] rd);
    drive(op, a, b, imm, immf, immsign, wb, rd);
    tick();
    bus.v_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(OP_ADD, 32'd5, 32'd7, 16'd0, 1'b0, 1'b0, 1'b1, 5'd3);
    tick();
    tick();
    n_cmp++; if (bus.v_o !== 1'b0) begin n_err++; $display("FAIL rst_v: got %b want 0", bus.v_o); end
    n_cmp++; if (bus.result_o !== 32'd0) begin n_err++; $display("FAIL rst_result: got %h want 0", bus.result_o); end
    n_cmp++; if (bus.wb_o !== 1'b0) begin n_err++; $display("FAIL rst_wb: got %b want 0", bus.wb_o); end
    n_cmp++; if (bus.wb_r_o !== 5'd0) begin n_err++; $display("FAIL rst_wb_r: got %h want 0", bus.wb_r_o); end
    n_cmp++; if (bus.flags_o !== 4'b0000) begin n_err++; $display("FAIL rst_flags: got %b want 0000", bus.flags_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL rst_stall_o: got %b want 0", bus.stall_o); end
    bus.v_i = 1'b0;
    reset   = 1'b1;
    tick();
    n_cmp++; if (bus.v_o !== 1'b0) begin n_err++; $display("FAIL rst_idle_v: got %b want 0", bus.v_o); end
  endtask

  task automatic test_add();
    issue(OP_ADD, 32'd5, 32'd7, 16'd0, 1'b0, 1'b0, 1'b1, 5'd3);
    n_cmp++; if (bus.v_o !== 1'b1) begin n_err++; $display("FAIL add_v: got %b want 1", bus.v_o); end
    n_cmp++; if (bus.result_o !== 32'd12) begin n_err++; $display("FAIL add_result: got %h want %h", bus.result_o, 32'd12); end
    n_cmp++; if (bus.wb_o !== 1'b1) begin n_err++; $display("FAIL add_wb: got %b want 1", bus.wb_o); end
    n_cmp++; if (bus.wb_r_o !== 5'd3) begin n_err++; $display("FAIL add_wb_r: got %h want 3", bus.wb_r_o); end
    tick();
    n_cmp++; if (bus.v_o !== 1'b0) begin n_err++; $display("FAIL add_v_drop: got %b want 0", bus.v_o); end
    n_cmp++; if (bus.wb_o !== 1'b0) begin n_err++; $display("FAIL add_wb_drop: got %b want 0", bus.wb_o); end
    n_cmp++; if (bus.result_o !== 32'd12) begin n_err++; $display("FAIL add_hold: got %h want %h", bus.result_o, 32'd12); end
    issue(OP_ADD, 32'hFFFF_FFFF, 32'd0, 16'h0002, 1'b1, 1'b0, 1'b1, 5'd4);
    n_cmp++; if (bus.result_o !== 32'd1) begin n_err++; $display("FAIL add_wrap: got %h want 1", bus.result_o); end
  endtask

  task automatic test_sub_imm();
    issue(OP_SUB, 32'd3, 32'd0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 5'd7);
    n_cmp++; if (bus.result_o !== 32'd4) begin n_err++; $display("FAIL sub_sext: got %h want 4", bus.result_o); end
    n_cmp++; if (bus.wb_o !== 1'b0) begin n_err++; $display("FAIL sub_wb_off: got %b want 0", bus.wb_o); end
    n_cmp++; if (bus.wb_r_o !== 5'd7) begin n_err++; $display("FAIL sub_wb_r: got %h want 7", bus.wb_r_o); end
    issue(OP_SUB, 32'd3, 32'd0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 5'd8);
    n_cmp++; if (bus.result_o !== 32'hFFFF_0004) begin n_err++; $display("FAIL sub_zext: got %h want ffff0004", bus.result_o); end
    n_cmp++; if (bus.wb_o !== 1'b1) begin n_err++; $display("FAIL sub_wb_on: got %b want 1", bus.wb_o); end
  endtask

  task automatic test_mul();
    issue(OP_MUL, 32'h0001_0000, 32'h0001_0001, 16'd0, 1'b0, 1'b0, 1'b1, 5'd9);
    n_cmp++; if (bus.result_o !== 32'h0001_0000) begin n_err++; $display("FAIL mul_trunc: got %h want 00010000", bus.result_o); end
    issue(OP_MUL, 32'd7, 32'd6, 16'd0, 1'b0, 1'b0, 1'b1, 5'd9);
    n_cmp++; if (bus.result_o !== 32'd42) begin n_err++; $display("FAIL mul_small: got %h want 2a", bus.result_o); end
    issue(OP_MUL, 32'd3, 32'd0, 16'hFFFE, 1'b1, 1'b1, 1'b1, 5'd9);
    n_cmp++; if (bus.result_o !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mul_imm: got %h want fffffffa", bus.result_o); end
  endtask

  task automatic test_cmp_flags();
    issue(OP_CMP, 32'd5, 32'd5, 16'd0, 1'b0, 1'b0, 1'b1, 5'd2);
    n_cmp++; if (bus.flags_o !== 4'b0100) begin n_err++; $display("FAIL cmp_eq_flags: got %b want 0100", bus.flags_o); end
    n_cmp++; if (bus.result_o !== 32'd0) begin n_err++; $display("FAIL cmp_result: got %h want 0", bus.result_o); end
    n_cmp++; if (bus.wb_o !== 1'b0) begin n_err++; $display("FAIL cmp_wb: got %b want 0", bus.wb_o); end
    n_cmp++; if (bus.v_o !== 1'b1) begin n_err++; $display("FAIL cmp_v: got %b want 1", bus.v_o); end
    issue(OP_CMP, 32'd0, 32'd1, 16'd0, 1'b0, 1'b0, 1'b0, 5'd2);
    n_cmp++; if (bus.flags_o !== 4'b1010) begin n_err++; $display("FAIL cmp_lt_flags: got %b want 1010", bus.flags_o); end
    issue(OP_ADD, 32'd1, 32'd1, 16'd0, 1'b0, 1'b0, 1'b1, 5'd2);
    n_cmp++; if (bus.flags_o !== 4'b1010) begin n_err++; $display("FAIL cmp_add_keep: got %b want 1010", bus.flags_o); end
    n_cmp++; if (bus.result_o !== 32'd2) begin n_err++; $display("FAIL cmp_add_res: got %h want 2", bus.result_o); end
    issue(OP_CMP, 32'h8000_0000, 32'd1, 16'd0, 1'b0, 1'b0, 1'b0, 5'd2);
    n_cmp++; if (bus.flags_o !== 4'b0001) begin n_err++; $display("FAIL cmp_ovf_flags: got %b want 0001", bus.flags_o); end
    issue(OP_NOP, 32'd9, 32'd9, 16'd0, 1'b0, 1'b0, 1'b1, 5'd6);
    n_cmp++; if (bus.result_o !== 32'd0) begin n_err++; $display("FAIL nop_result: got %h want 0", bus.result_o); end
    n_cmp++; if (bus.wb_o !== 1'b1) begin n_err++; $display("FAIL nop_wb: got %b want 1", bus.wb_o); end
    n_cmp++; if (bus.flags_o !== 4'b0001) begin n_err++; $display("FAIL nop_flags: got %b want 0001", bus.flags_o); end
  endtask

  task automatic test_stall();
    issue(OP_ADD, 32'd20, 32'd22, 16'd0, 1'b0, 1'b0, 1'b1, 5'd11);
    n_cmp++; if (bus.result_o !== 32'd42) begin n_err++; $display("FAIL stall_pre: got %h want 2a", bus.result_o); end
    bus.stall_i = 1'b1;
    drive(OP_CMP, 32'd0, 32'd1, 16'd0, 1'b0, 1'b0, 1'b0, 5'd12);
    #1;
    n_cmp++; if (bus.stall_o !== 1'b1) begin n_err++; $display("FAIL stall_o: got %b want 1", bus.stall_o); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (bus.v_o !== 1'b1) begin n_err++; $display("FAIL stall_v_hold: got %b want 1", bus.v_o); end
      n_cmp++; if (bus.result_o !== 32'd42) begin n_err++; $display("FAIL stall_res_hold: got %h want 2a", bus.result_o); end
      n_cmp++; if (bus.wb_r_o !== 5'd11) begin n_err++; $display("FAIL stall_wb_r_hold: got %h want 0b", bus.wb_r_o); end
      n_cmp++; if (bus.flags_o !== 4'b0001) begin n_err++; $display("FAIL stall_flags_hold: got %b want 0001", bus.flags_o); end
    end
    bus.stall_i = 1'b0;
    bus.v_i     = 1'b0;
    tick();
    n_cmp++; if (bus.v_o !== 1'b0) begin n_err++; $display("FAIL stall_release_v: got %b want 0", bus.v_o); end
    n_cmp++; if (bus.result_o !== 32'd42) begin n_err++; $display("FAIL stall_ignored: got %h want 2a", bus.result_o); end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  ops [3];
    logic [31:0] as  [3];
    logic [31:0] bs  [3];
    logic [31:0] exp [3];
    ops = '{OP_ADD, OP_SUB, OP_MUL};
    as  = '{32'd1, 32'd100, 32'h10};
    bs  = '{32'd2, 32'd200, 32'h10};
    exp = '{32'd3, 32'hFFFF_FF9C, 32'h100};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], as[i], bs[i], 16'd0, 1'b0, 1'b0, 1'b1, 5'(i + 1));
      tick();
      n_cmp++; if (bus.result_o !== exp[i]) begin n_err++; $display("FAIL b2b_result%0d: got %h want %h", i, bus.result_o, exp[i]); end
      n_cmp++; if (bus.wb_r_o !== 5'(i + 1)) begin n_err++; $display("FAIL b2b_wb_r%0d: got %h want %h", i, bus.wb_r_o, 5'(i + 1)); end
      n_cmp++; if (bus.v_o !== 1'b1) begin n_err++; $display("FAIL b2b_v%0d: got %b want 1", i, bus.v_o); end
    end
    bus.v_i = 1'b0;
    tick();
    n_cmp++; if (bus.v_o !== 1'b0) begin n_err++; $display("FAIL b2b_end_v: got %b want 0", bus.v_o); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    tick();
    n_cmp++; if (bus.result_o !== 32'd0) begin n_err++; $display("FAIL mrst_result: got %h want 0", bus.result_o); end
    n_cmp++; if (bus.flags_o !== 4'b0000) begin n_err++; $display("FAIL mrst_flags: got %b want 0000", bus.flags_o); end
    n_cmp++; if (bus.wb_r_o !== 5'd0) begin n_err++; $display("FAIL mrst_wb_r: got %h want 0", bus.wb_r_o); end
    reset = 1'b1;
    tick();
  endtask

`ifdef EXEC_MULTICYCLE_DIV_EN
  task automatic test_div_latency();
    int lat;
    int busy_cnt;
    lat      = 0;
    busy_cnt = 0;
    issue(OP_DIV, 32'd100, 32'd7, 16'd0, 1'b0, 1'b0, 1'b1, 5'd9);
    n_cmp++; if (bus.stall_o !== 1'b1) begin n_err++; $display("FAIL div_stall_o: got %b want 1", bus.stall_o); end
    n_cmp++; if (bus.v_o !== 1'b0) begin n_err++; $display("FAIL div_v_low: got %b want 0", bus.v_o); end
    drive(OP_ADD, 32'd1, 32'd1, 16'd0, 1'b0, 1'b0, 1'b1, 5'd1);
    while (bus.v_o !== 1'b1 && lat < 100) begin
      if (bus.busy_o === 1'b1) busy_cnt++;
      else bus.v_i = 1'b0;
      tick();
      lat++;
    end
    bus.v_i = 1'b0;
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL div_latency: got %0d want 33", lat); end
    n_cmp++; if (busy_cnt !== 32) begin n_err++; $display("FAIL div_busy_cycles: got %0d want 32", busy_cnt); end
    n_cmp++; if (bus.result_o !== 32'd14) begin n_err++; $display("FAIL div_quotient: got %h want 0e", bus.result_o); end
    n_cmp++; if (bus.wb_o !== 1'b1) begin n_err++; $display("FAIL div_wb: got %b want 1", bus.wb_o); end
    n_cmp++; if (bus.wb_r_o !== 5'd9) begin n_err++; $display("FAIL div_wb_r: got %h want 9", bus.wb_r_o); end
    tick();
    n_cmp++; if (bus.v_o !== 1'b0) begin n_err++; $display("FAIL div_single_pulse: got %b want 0", bus.v_o); end
  endtask

  task automatic test_div_zero();
    issue(OP_DIV, 32'd55, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1, 5'd12);
    n_cmp++; if (bus.result_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div0_result: got %h want ffffffff", bus.result_o); end
    n_cmp++; if (bus.v_o !== 1'b1) begin n_err++; $display("FAIL div0_v: got %b want 1", bus.v_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL div0_busy: got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.wb_r_o !== 5'd12) begin n_err++; $display("FAIL div0_wb_r: got %h want 0c", bus.wb_r_o); end
  endtask

  task automatic test_div_stall_done();
    issue(OP_ADD, 32'd1, 32'd2, 16'd0, 1'b0, 1'b0, 1'b1, 5'd1);
    issue(OP_DIV, 32'd50, 32'd5, 16'd0, 1'b0, 1'b0, 1'b0, 5'd13);
    for (int i = 0; i < 32; i++) tick();
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.v_o !== 1'b0) begin n_err++; $display("FAIL done_stall_v%0d: got %b want 0", i, bus.v_o); end
      n_cmp++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL done_stall_busy%0d: got %b want 1", i, bus.busy_o); end
      n_cmp++; if (bus.result_o !== 32'd3) begin n_err++; $display("FAIL done_stall_res%0d: got %h want 3", i, bus.result_o); end
    end
    bus.stall_i = 1'b0;
    tick();
    n_cmp++; if (bus.v_o !== 1'b1) begin n_err++; $display("FAIL done_release_v: got %b want 1", bus.v_o); end
    n_cmp++; if (bus.result_o !== 32'd10) begin n_err++; $display("FAIL done_release_res: got %h want 0a", bus.result_o); end
    n_cmp++; if (bus.wb_o !== 1'b0) begin n_err++; $display("FAIL done_release_wb: got %b want 0", bus.wb_o); end
    n_cmp++; if (bus.wb_r_o !== 5'd13) begin n_err++; $display("FAIL done_release_wb_r: got %h want 0d", bus.wb_r_o); end
    tick();
    n_cmp++; if (bus.v_o !== 1'b0) begin n_err++; $display("FAIL done_one_pulse: got %b want 0", bus.v_o); end
  endtask

  task automatic test_div_reset();
    logic seen_v;
    seen_v = 1'b0;
    issue(OP_CMP, 32'd5, 32'd5, 16'd0, 1'b0, 1'b0, 1'b0, 5'd1);
    issue(OP_DIV, 32'd100, 32'd7, 16'd0, 1'b0, 1'b0, 1'b1, 5'd15);
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL divrst_busy: got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.v_o !== 1'b0) begin n_err++; $display("FAIL divrst_v: got %b want 0", bus.v_o); end
    n_cmp++; if (bus.flags_o !== 4'b0000) begin n_err++; $display("FAIL divrst_flags: got %b want 0000", bus.flags_o); end
    n_cmp++; if (bus.wb_r_o !== 5'd0) begin n_err++; $display("FAIL divrst_wb_r: got %h want 0", bus.wb_r_o); end
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.v_o === 1'b1) seen_v = 1'b1;
    end
    n_cmp++; if (seen_v !== 1'b0) begin n_err++; $display("FAIL divrst_late_v: got %b want 0", seen_v); end
  endtask
`else
  task automatic test_div_off();
    issue(OP_ADD, 32'd1, 32'd1, 16'd0, 1'b0, 1'b0, 1'b1, 5'd1);
    issue(OP_DIV, 32'd100, 32'd7, 16'd0, 1'b0, 1'b0, 1'b1, 5'd14);
    n_cmp++; if (bus.v_o !== 1'b1) begin n_err++; $display("FAIL divoff_v: got %b want 1", bus.v_o); end
    n_cmp++; if (bus.result_o !== 32'd0) begin n_err++; $display("FAIL divoff_result: got %h want 0", bus.result_o); end
    n_cmp++; if (bus.wb_o !== 1'b1) begin n_err++; $display("FAIL divoff_wb: got %b want 1", bus.wb_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL divoff_busy: got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.wb_r_o !== 5'd14) begin n_err++; $display("FAIL divoff_wb_r: got %h want 0e", bus.wb_r_o); end
    issue(OP_ADD, 32'd1, 32'd1, 16'd0, 1'b0, 1'b0, 1'b1, 5'd1);
    issue(OP_DIV, 32'd9, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd2);
    n_cmp++; if (bus.result_o !== 32'd0) begin n_err++; $display("FAIL divoff_zero_res: got %h want 0", bus.result_o); end
    n_cmp++; if (bus.wb_o !== 1'b0) begin n_err++; $display("FAIL divoff_zero_wb: got %b want 0", bus.wb_o); end
  endtask
`endif

  initial begin
    reset         = 1'b0;
    bus.v_i       = 1'b0;
    bus.stall_i   = 1'b0;
    bus.opecode_i = 7'd0;
    bus.opr0_i    = 32'd0;
    bus.opr1_i    = 32'd0;
    bus.imm_i     = 16'd0;
    bus.immf_i    = 1'b0;
    bus.immsign_i = 1'b0;
    bus.wb_i      = 1'b0;
    bus.wb_r_i    = 5'd0;
    test_reset();
    test_add();
    test_sub_imm();
    test_mul();
    test_cmp_flags();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef EXEC_MULTICYCLE_DIV_EN
    test_div_latency();
    test_div_zero();
    test_div_stall_done();
    test_div_reset();
`else
    test_div_off();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
